// File: rtl/score_pkg.sv
// Shared types and glyph helpers for the score display path.
package score_pkg;

  typedef logic [3:0] digit_t;

  localparam digit_t      BLANK_CODE = 4'd10;
  localparam int unsigned GLYPH_COLS = 8;
  localparam int unsigned GLYPH_ROWS = 4;

  // Pick one pixel out of a 4x8 glyph word: row 0 is the top byte, bit 7 of a row is column 0.
  function automatic logic glyph_bit(input logic [31:0] word, input logic [1:0] row,
                                     input logic [2:0] col);
    logic [4:0] idx;
    idx = 5'd31 - {row, 3'b000} - 5'(col);
    return word[idx];
  endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Four-digit BCD score counter with synchronous clear and saturation at 9999.
module bcd_score_counter
  import score_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        game_reset,
  input  logic        score_tick,
  output logic [15:0] score_bcd
);

  logic [15:0] score_q;
  logic [15:0] score_d;
  logic        carry;
  digit_t      dig;

  // Next score: clear wins over tick; ripple carry through the digits, hold at 9999.
  always_comb begin
    score_d = score_q;
    carry   = 1'b0;
    dig     = '0;
    if (game_reset) begin
      score_d = '0;
    end else if (score_tick && (score_q != 16'h9999)) begin
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
        dig = score_q[i*4 +: 4];
        if (carry) begin
          if (dig == 4'd9) begin
            score_d[i*4 +: 4] = 4'd0;
          end else begin
            score_d[i*4 +: 4] = dig + 4'd1;
            carry             = 1'b0;
          end
        end
      end
    end
  end

  // Score register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) score_q <= '0;
    else       score_q <= score_d;
  end

  assign score_bcd = score_q;

endmodule

// File: rtl/score_renderer.sv
// Score box renderer: per-frame score snapshot, font ROM addressing and pixel decode.
module score_renderer
  import score_pkg::*;
#(
  parameter int unsigned X0         = 560,
  parameter int unsigned Y0         = 16,
  parameter int unsigned SCALE      = 2,
  parameter int unsigned GAP        = 4,
  parameter int unsigned LEAD_BLANK = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        game_reset,
  input  logic        score_tick,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic [3:0]  rom_addr,
  input  logic [31:0] rom_data,
  output logic        pixel_on,
  output logic [15:0] score_bcd
);

  localparam int unsigned CELL_W = GLYPH_COLS * SCALE;
  localparam int unsigned CELL_H = GLYPH_ROWS * SCALE;
  localparam int unsigned PITCH  = CELL_W + GAP;
  localparam int unsigned BOX_W  = 4 * PITCH - GAP;

  logic [15:0] snap_q, snap_d;
  digit_t      rom_addr_q, rom_addr_d;
  logic [2:0]  col_a_q, col_a_d, col_b_q, col_b_d;
  logic [1:0]  row_a_q, row_a_d, row_b_q, row_b_d;
  logic        lit_a_q, lit_a_d, lit_b_q, lit_b_d;
  logic        pixel_on_q, pixel_on_d;

  logic [10:0] dx, cell_x;
  logic [9:0]  dy;
  logic [1:0]  idx;
  logic        in_box, blank;
  digit_t      digit;

  bcd_score_counter u_counter (
    .clk        (clk),
    .reset      (reset),
    .game_reset (game_reset),
    .score_tick (score_tick),
    .score_bcd  (score_bcd)
  );

  // Display copy of the score, refreshed only at the very first pixel of a frame.
  always_comb begin
    snap_d = snap_q;
    if ((hcount == 11'd0) && (vcount == 10'd0)) snap_d = score_bcd;
  end

  // Stage A: locate the raster inside the box and pick the glyph to fetch.
  always_comb begin
    dx     = hcount - 11'(X0);
    dy     = vcount - 10'(Y0);
    idx    = 2'(dx / 11'(PITCH));
    cell_x = dx % 11'(PITCH);
    in_box = (hcount >= 11'(X0)) && (dx < 11'(BOX_W)) && (cell_x < 11'(CELL_W)) &&
             (vcount >= 10'(Y0)) && (dy < 10'(CELL_H));
    digit  = snap_q[{~idx, 2'b00} +: 4];
    blank  = 1'b0;
    if (LEAD_BLANK != 0) begin
      case (idx)
        2'd0:    blank = (snap_q[15:12] == 4'd0);
        2'd1:    blank = (snap_q[15:8]  == 8'd0);
        2'd2:    blank = (snap_q[15:4]  == 12'd0);
        default: blank = 1'b0;
      endcase
    end
    lit_a_d    = in_box && !blank;
    rom_addr_d = lit_a_d ? digit : BLANK_CODE;
    col_a_d    = 3'(cell_x / 11'(SCALE));
    row_a_d    = 2'(dy / 10'(SCALE));
  end

  // Stages B and C: align coordinates with the ROM word, then pick the pixel.
  always_comb begin
    col_b_d    = col_a_q;
    row_b_d    = row_a_q;
    lit_b_d    = lit_a_q;
    pixel_on_d = lit_b_q && glyph_bit(rom_data, row_b_q, col_b_q);
  end

  // Pipeline and snapshot registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_q     <= '0;
      rom_addr_q <= BLANK_CODE;
      col_a_q    <= '0;
      row_a_q    <= '0;
      lit_a_q    <= 1'b0;
      col_b_q    <= '0;
      row_b_q    <= '0;
      lit_b_q    <= 1'b0;
      pixel_on_q <= 1'b0;
    end else begin
      snap_q     <= snap_d;
      rom_addr_q <= rom_addr_d;
      col_a_q    <= col_a_d;
      row_a_q    <= row_a_d;
      lit_a_q    <= lit_a_d;
      col_b_q    <= col_b_d;
      row_b_q    <= row_b_d;
      lit_b_q    <= lit_b_d;
      pixel_on_q <= pixel_on_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign pixel_on = pixel_on_q;

endmodule
